issue_inflight_arbiter: RTL and testbench
=========================================

# issue_inflight_arbiter

Per-wavefront issue arbiter for the issue stage. It keeps an inflight-instruction count for each wavefront and picks at most one ready wavefront per cycle with a round-robin policy. A wavefront is excluded while it is at its inflight limit, or while it is requesting a drain and still has instructions outstanding. Retirements arrive from the VGPR, SGPR and branch writeback paths tagged with a wavefront ID, and the per-wavefront empty and full flags are exported to the rest of the issue logic.

## Interface
- NUM_WF, 8: number of wavefronts; must be a power of two, at least 2. WF_ID_W = log2(NUM_WF).
- MAX_INFLIGHT, 15: inflight limit per wavefront; counter width CNT_W = 4. MAX_INFLIGHT must be ≤ 2^CNT_W − 1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wf_ready  in  NUM_WF  wavefront has a decoded instruction ready to issue.
- wf_drain  in  NUM_WF  wavefront may issue only when it has zero inflight instructions (waitcnt/barrier/end).
- issue_stall  in  1  downstream cannot accept; no grant this cycle.
- retire_vgpr_en, retire_sgpr_en, retire_branch_en  in  1 each  retirement pulse from each writeback path.
- retire_vgpr_wfid, retire_sgpr_wfid, retire_branch_wfid  in  WF_ID_W each  wavefront of the matching retirement.
- issued_valid  out  1  registered; one instruction issued.
- issued_wfid  out  WF_ID_W  registered; wavefront issued. Holds its last value when issued_valid is 0.
- no_inflight  out  NUM_WF  per wavefront, counter == 0.
- max_inflight  out  NUM_WF  per wavefront, counter == MAX_INFLIGHT.
- underflow_err  out  1  sticky; a retirement arrived that would take a counter below 0.

## Operation
**Reset state** (rst_n low; applies immediately, even mid-operation):
- All counters are 0.
- issued_valid = 0, issued_wfid = 0.
- underflow_err = 0.
- Round-robin pointer = NUM_WF−1, so wavefront 0 has top priority first.
- Outputs after reset: no_inflight is all ones, max_inflight is all zeros.

**Eligibility** of wavefront i in a cycle:
- Requires wf_ready[i], and ~max_inflight[i], and ~(wf_drain[i] & ~no_inflight[i]), and ~issue_stall.
- Only registered counter values are used. Retirements in the same cycle are not bypassed.

**Arbitration:**
- Round-robin search starts at (pointer+1) mod NUM_WF.
- The first eligible wavefront is granted.
- On a grant, the pointer is set to the granted ID. With no grant, the pointer holds.

**Counter update** for wavefront i, each cycle:
- next = cnt + inc − dec.
- inc = 1 if i was granted this cycle.
- dec = number of retire_*_en whose wfid == i (0..3). All three paths may target the same wavefront in the same cycle.
- Compute at CNT_W+2 bits, signed.
- If the result is < 0: store 0 and set underflow_err. It stays set until reset.
- The result can never exceed MAX_INFLIGHT, because a full wavefront is not eligible.

**Flags and drain:**
- no_inflight and max_inflight are decoded combinationally from the registered counters.
- A wavefront in drain becomes eligible the cycle after its counter reaches 0.

## Timing
- A grant decided in cycle t gives issued_valid/issued_wfid high in cycle t+1.
- The counter increment from that grant is visible in t+1.
- A retire pulse in cycle t is reflected in the counter and flags at t+1. It enables eligibility no earlier than t+1.
- Maximum throughput is one issue per cycle, and back-to-back issue from the same wavefront is allowed.
- A wavefront at MAX_INFLIGHT−1 that issues in cycle t is blocked in t+1 unless a retirement for it is also applied at that edge.
- issue_stall in cycle t gives issued_valid = 0 in t+1. Counters then change by retirements only.
- Simultaneous issue and retire for the same wavefront apply net: e.g. cnt 5 with 1 issue and 2 retires gives 4.

## Test plan
- **Reset:** drive rst_n low in mid-run with counters nonzero. All outputs must take their reset values asynchronously. After release, wf_ready = 8'hFF must give issued_wfid 0, 1, 2, … on consecutive cycles.
- **Fill to limit:** only wf3 ready, no retires, for 20 cycles. Exactly 15 issues must occur, then max_inflight[3] = 1 and issued_valid stays 0. One retire_vgpr for wf3 must give one more issue two cycles later.
- **Triple retire:** wf2 count 5; same cycle, all three retire paths target wf2 and wf2 is granted. The count must be 3 next cycle. A triple retire on wf1 with count 2 must give count 0 and underflow_err = 1, which remains set.
- **Drain:** wf4 count 2 with wf_drain[4] and wf_ready[4] high. No issue until both retirements land. issued_wfid 4 must appear exactly 2 cycles after the retirement that brings the count to 0.
- **Stall and fairness:** wf_ready = 8'b1000_0001, pointer at 0, issue_stall high for 3 cycles. No issues and the pointer holds. Then the sequence must be 7, 0, 7, 0.

Source files
------------

// File: rtl/issue_inflight_arbiter.sv
// Per-wavefront issue arbiter: round-robin grant among ready wavefronts,
// with per-wavefront inflight counters fed by three retirement paths.
module issue_inflight_arbiter #(
  parameter int unsigned NUM_WF       = 8,
  parameter int unsigned MAX_INFLIGHT = 15,
  parameter int unsigned CNT_W        = 4,
  localparam int unsigned WF_ID_W     = $clog2(NUM_WF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_WF-1:0]  wf_ready,
  input  logic [NUM_WF-1:0]  wf_drain,
  input  logic               issue_stall,
  input  logic               retire_vgpr_en,
  input  logic               retire_sgpr_en,
  input  logic               retire_branch_en,
  input  logic [WF_ID_W-1:0] retire_vgpr_wfid,
  input  logic [WF_ID_W-1:0] retire_sgpr_wfid,
  input  logic [WF_ID_W-1:0] retire_branch_wfid,
  output logic               issued_valid,
  output logic [WF_ID_W-1:0] issued_wfid,
  output logic [NUM_WF-1:0]  no_inflight,
  output logic [NUM_WF-1:0]  max_inflight,
  output logic               underflow_err
);

  logic [NUM_WF-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_WF-1:0][CNT_W-1:0] cnt_d;
  logic [WF_ID_W-1:0]           ptr_q;
  logic [NUM_WF-1:0]            eligible;
  logic                         grant_valid;
  logic [WF_ID_W-1:0]           grant_id;
  logic [WF_ID_W-1:0]           cand;
  logic                         uflow;
  logic [1:0]                   dec;
  logic signed [CNT_W+1:0]      sum;

  always_comb begin
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      no_inflight[i]  = (cnt_q[i] == '0);
      max_inflight[i] = (cnt_q[i] == CNT_W'(MAX_INFLIGHT));
    end
  end

  // Eligibility uses registered counters only; retirements are not bypassed.
  assign eligible = wf_ready & ~max_inflight & ~(wf_drain & ~no_inflight)
                  & {NUM_WF{~issue_stall}};

  // Search from ptr+1 upward, wrapping; k == NUM_WF wraps back to ptr itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_WF; k++) begin
      cand = ptr_q + WF_ID_W'(k);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    uflow = 1'b0;
    dec   = '0;
    sum   = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      dec = 2'(retire_vgpr_en   && (retire_vgpr_wfid   == WF_ID_W'(i)))
          + 2'(retire_sgpr_en   && (retire_sgpr_wfid   == WF_ID_W'(i)))
          + 2'(retire_branch_en && (retire_branch_wfid == WF_ID_W'(i)));
      sum = $signed({2'b00, cnt_q[i]})
          + $signed((CNT_W+2)'(grant_valid && (grant_id == WF_ID_W'(i))))
          - $signed({{CNT_W{1'b0}}, dec});
      if (sum < $signed((CNT_W+2)'(0))) begin
        cnt_d[i] = '0;
        uflow    = 1'b1;
      end else begin
        cnt_d[i] = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      ptr_q         <= '1;
      issued_valid  <= 1'b0;
      issued_wfid   <= '0;
      underflow_err <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      issued_valid <= grant_valid;
      if (grant_valid) begin
        ptr_q       <= grant_id;
        issued_wfid <= grant_id;
      end
      if (uflow) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_inflight_arbiter.sv
// Directed bench for issue_inflight_arbiter: reset, fill, triple retire,
// drain and stall/fairness scenarios with hand-computed expectations.
module tb_issue_inflight_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] wf_ready;
  logic [7:0] wf_drain;
  logic       issue_stall;
  logic       retire_vgpr_en, retire_sgpr_en, retire_branch_en;
  logic [2:0] retire_vgpr_wfid, retire_sgpr_wfid, retire_branch_wfid;
  logic       issued_valid;
  logic [2:0] issued_wfid;
  logic [7:0] no_inflight;
  logic [7:0] max_inflight;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;
  int n_issue;

  issue_inflight_arbiter #(.NUM_WF(8), .MAX_INFLIGHT(15), .CNT_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wf_ready           (wf_ready),
    .wf_drain           (wf_drain),
    .issue_stall        (issue_stall),
    .retire_vgpr_en     (retire_vgpr_en),
    .retire_sgpr_en     (retire_sgpr_en),
    .retire_branch_en   (retire_branch_en),
    .retire_vgpr_wfid   (retire_vgpr_wfid),
    .retire_sgpr_wfid   (retire_sgpr_wfid),
    .retire_branch_wfid (retire_branch_wfid),
    .issued_valid       (issued_valid),
    .issued_wfid        (issued_wfid),
    .no_inflight        (no_inflight),
    .max_inflight       (max_inflight),
    .underflow_err      (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_retire(input logic [2:0] en, input logic [2:0] wfid);
    retire_vgpr_en     = en[0];
    retire_sgpr_en     = en[1];
    retire_branch_en   = en[2];
    retire_vgpr_wfid   = wfid;
    retire_sgpr_wfid   = wfid;
    retire_branch_wfid = wfid;
  endtask

  task automatic clear_in();
    wf_ready    = '0;
    wf_drain    = '0;
    issue_stall = 1'b0;
    set_retire(3'b000, 3'd0);
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("por_valid", 32'(issued_valid), 32'd0);
    check_eq("por_wfid", 32'(issued_wfid), 32'd0);
    check_eq("por_noinf", 32'(no_inflight), 32'hFF);
    check_eq("por_maxinf", 32'(max_inflight), 32'h00);
    check_eq("por_uflow", 32'(underflow_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // all ready: round-robin from wf0
    wf_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("rr1_valid", 32'(issued_valid), 32'd1);
      check_eq("rr1_wfid", 32'(issued_wfid), 32'(i));
    end

    // mid-run asynchronous reset with all counters at 1
    check_eq("pre_rst_noinf", 32'(no_inflight), 32'h00);
    rst_n = 1'b0;
    wf_ready = '0;
    #1;
    check_eq("arst_valid", 32'(issued_valid), 32'd0);
    check_eq("arst_wfid", 32'(issued_wfid), 32'd0);
    check_eq("arst_noinf", 32'(no_inflight), 32'hFF);
    check_eq("arst_maxinf", 32'(max_inflight), 32'h00);
    check_eq("arst_uflow", 32'(underflow_err), 32'd0);
    tick();
    rst_n = 1'b1;
    wf_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("rr2_valid", 32'(issued_valid), 32'd1);
      check_eq("rr2_wfid", 32'(issued_wfid), 32'(i));
    end

    // fill wf3 to its limit
    do_reset();
    wf_ready = 8'h08;
    n_issue = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (issued_valid) n_issue++;
    end
    check_eq("fill_count", 32'(n_issue), 32'd15);
    check_eq("fill_max3", 32'(max_inflight[3]), 32'd1);
    check_eq("fill_valid", 32'(issued_valid), 32'd0);
    set_retire(3'b001, 3'd3);
    tick();
    set_retire(3'b000, 3'd0);
    check_eq("fill_ret_valid", 32'(issued_valid), 32'd0);
    check_eq("fill_ret_max3", 32'(max_inflight[3]), 32'd0);
    tick();
    check_eq("fill_reissue_valid", 32'(issued_valid), 32'd1);
    check_eq("fill_reissue_wfid", 32'(issued_wfid), 32'd3);
    tick();
    check_eq("fill_reblock_valid", 32'(issued_valid), 32'd0);
    check_eq("fill_reblock_max3", 32'(max_inflight[3]), 32'd1);

    // triple retire on wf2 (count 5) together with a grant
    do_reset();
    wf_ready = 8'h04;
    repeat (5) tick();
    check_eq("tri_noinf2_pre", 32'(no_inflight[2]), 32'd0);
    set_retire(3'b111, 3'd2);
    tick();
    check_eq("tri_grant_valid", 32'(issued_valid), 32'd1);
    check_eq("tri_grant_wfid", 32'(issued_wfid), 32'd2);
    clear_in();
    set_retire(3'b001, 3'd2);
    tick();
    check_eq("tri_cnt2_noinf", 32'(no_inflight[2]), 32'd0);
    set_retire(3'b010, 3'd2);
    tick();
    check_eq("tri_cnt1_noinf", 32'(no_inflight[2]), 32'd0);
    set_retire(3'b100, 3'd2);
    tick();
    check_eq("tri_cnt0_noinf", 32'(no_inflight[2]), 32'd1);
    check_eq("tri_no_uflow", 32'(underflow_err), 32'd0);
    clear_in();

    // triple retire on wf1 with count 2 underflows
    wf_ready = 8'h02;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("uf_issue_wfid", 32'(issued_wfid), 32'd1);
    end
    clear_in();
    set_retire(3'b111, 3'd1);
    tick();
    clear_in();
    check_eq("uf_noinf1", 32'(no_inflight[1]), 32'd1);
    check_eq("uf_set", 32'(underflow_err), 32'd1);
    repeat (3) tick();
    check_eq("uf_sticky", 32'(underflow_err), 32'd1);

    // drain: wf4 waits for both retirements
    do_reset();
    wf_ready = 8'h10;
    repeat (2) tick();
    check_eq("dr_fill_wfid", 32'(issued_wfid), 32'd4);
    wf_drain = 8'h10;
    tick();
    check_eq("dr_wait1", 32'(issued_valid), 32'd0);
    tick();
    check_eq("dr_wait2", 32'(issued_valid), 32'd0);
    set_retire(3'b001, 3'd4);
    tick();
    set_retire(3'b000, 3'd0);
    check_eq("dr_ret1_valid", 32'(issued_valid), 32'd0);
    tick();
    check_eq("dr_cnt1_valid", 32'(issued_valid), 32'd0);
    check_eq("dr_cnt1_noinf", 32'(no_inflight[4]), 32'd0);
    set_retire(3'b010, 3'd4);
    tick();
    set_retire(3'b000, 3'd0);
    check_eq("dr_ret2_valid", 32'(issued_valid), 32'd0);
    check_eq("dr_ret2_noinf", 32'(no_inflight[4]), 32'd1);
    tick();
    check_eq("dr_issue_valid", 32'(issued_valid), 32'd1);
    check_eq("dr_issue_wfid", 32'(issued_wfid), 32'd4);
    tick();
    check_eq("dr_reblock", 32'(issued_valid), 32'd0);

    // stall then fairness between wf7 and wf0
    do_reset();
    wf_ready = 8'h01;
    tick();
    check_eq("st_seed_wfid", 32'(issued_wfid), 32'd0);
    wf_ready = 8'h81;
    issue_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("st_stall_valid", 32'(issued_valid), 32'd0);
    end
    check_eq("st_hold_wfid", 32'(issued_wfid), 32'd0);
    issue_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("st_rr_valid", 32'(issued_valid), 32'd1);
      check_eq("st_rr_wfid", 32'(issued_wfid), (i % 2 == 0) ? 32'd7 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
